// File: rtl/rom_load_ctrl_pkg.sv
// Shared definitions for the ROM download controller: FSM states, region map
// and region indices into the one-hot write enable.
package rom_load_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHECK,
        ST_SETTLE,
        ST_RUN,
        ST_ERROR
    } state_t;

    localparam logic [24:0] CPU_BASE    = 25'h0_0000;
    localparam logic [24:0] CPU_SIZE    = 25'h0_8000;
    localparam logic [24:0] GFX_BASE    = 25'h0_8000;
    localparam logic [24:0] GFX_SIZE    = 25'h0_8000;
    localparam logic [24:0] SND_BASE    = 25'h1_0000;
    localparam logic [24:0] SND_SIZE    = 25'h0_0800;
    localparam logic [24:0] PROM_BASE   = 25'h1_0800;
    localparam logic [24:0] PROM_SIZE   = 25'h0_0800;
    localparam logic [24:0] TOTAL_BYTES = 25'h1_1000;

    localparam int REG_CPU  = 0;
    localparam int REG_GFX  = 1;
    localparam int REG_SND  = 2;
    localparam int REG_PROM = 3;
    localparam int NUM_REGIONS = 4;

    localparam logic [17:0] BYTE_COUNT_MAX = 18'h3_FFFF;

endpackage

// File: rtl/rom_load_ctrl_region_dec.sv
// Purely combinational region decode: download address to one-hot region
// select plus the offset within that region.
module rom_region_dec
    import rom_load_ctrl_pkg::*;
#(
    parameter int ADDR_W = 17
) (
    input  logic [24:0]            addr,
    output logic [NUM_REGIONS-1:0] sel,
    output logic [ADDR_W-1:0]      offset,
    output logic                   in_range
);

    logic [24:0] base;

    // Regions are contiguous, so an ordered chain of upper-bound compares is enough.
    always_comb begin
        sel      = '0;
        base     = '0;
        in_range = 1'b1;
        if (addr < CPU_BASE + CPU_SIZE) begin
            sel[REG_CPU] = 1'b1;
            base         = CPU_BASE;
        end else if (addr < GFX_BASE + GFX_SIZE) begin
            sel[REG_GFX] = 1'b1;
            base         = GFX_BASE;
        end else if (addr < SND_BASE + SND_SIZE) begin
            sel[REG_SND] = 1'b1;
            base         = SND_BASE;
        end else if (addr < PROM_BASE + PROM_SIZE) begin
            sel[REG_PROM] = 1'b1;
            base          = PROM_BASE;
        end else begin
            in_range = 1'b0;
        end
        offset = ADDR_W'(addr - base);
    end

endmodule

// File: rtl/rom_load_ctrl.sv
// ROM download controller: routes ioctl bytes into per-region ROM writes,
// validates the session length and holds the game core in reset until settled.
module rom_load_ctrl
    import rom_load_ctrl_pkg::*;
#(
    parameter int SETTLE_CYC = 256,
    parameter int ADDR_W     = 17
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    output logic [ADDR_W-1:0] rom_addr,
    output logic [7:0]        rom_data,
    output logic [3:0]        rom_we,
    output logic              core_reset,
    output logic              load_done,
    output logic              load_error,
    output logic [17:0]       byte_count,
    output logic [7:0]        checksum
);

    // SETTLE_CYC must be at least 1.
    localparam int CNT_W = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);

    state_t state;
    state_t next_state;

    logic             dl_q;
    logic             dl_armed;
    logic             dl_rise;
    logic             dl_fall;
    logic             oor;
    logic [CNT_W-1:0] settle_cnt;
    logic             load_entry;
    logic             accept_wr;

    logic [NUM_REGIONS-1:0] dec_sel;
    logic [ADDR_W-1:0]      dec_offset;
    logic                   dec_in_range;

    rom_region_dec #(
        .ADDR_W (ADDR_W)
    ) u_region_dec (
        .addr     (ioctl_addr),
        .sel      (dec_sel),
        .offset   (dec_offset),
        .in_range (dec_in_range)
    );

    // dl_armed blocks a session that was already running when reset released.
    assign dl_rise    = ioctl_download & ~dl_q & dl_armed;
    assign dl_fall    = ~ioctl_download & dl_q;
    assign load_entry = (next_state == ST_LOAD) && (state != ST_LOAD);
    assign accept_wr  = (state == ST_LOAD) && ioctl_wr;

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            dl_q     <= 1'b0;
            dl_armed <= 1'b0;
        end else begin
            state <= next_state;
            dl_q  <= ioctl_download;
            if (!ioctl_download) begin
                dl_armed <= 1'b1;
            end
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE: begin
                if (dl_rise) next_state = ST_LOAD;
            end
            ST_LOAD: begin
                if (dl_fall) next_state = ST_CHECK;
            end
            ST_CHECK: begin
                if (dl_rise) begin
                    next_state = ST_LOAD;
                end else if (({7'd0, byte_count} == TOTAL_BYTES) && !oor) begin
                    next_state = ST_SETTLE;
                end else begin
                    next_state = ST_ERROR;
                end
            end
            ST_SETTLE: begin
                if (dl_rise) begin
                    next_state = ST_LOAD;
                end else if (settle_cnt == SETTLE_LAST) begin
                    next_state = ST_RUN;
                end
            end
            ST_RUN, ST_ERROR: begin
                if (dl_rise) next_state = ST_LOAD;
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        core_reset = (state != ST_RUN);
        load_done  = (state == ST_RUN);
        load_error = (state == ST_ERROR);
    end

    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            settle_cnt <= '0;
        end else if (state == ST_SETTLE) begin
            settle_cnt <= settle_cnt + 1'b1;
        end else begin
            settle_cnt <= '0;
        end
    end

    // Write path is registered so rom_we/rom_addr/rom_data land one cycle after the strobe.
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            rom_we     <= '0;
            rom_addr   <= '0;
            rom_data   <= '0;
            byte_count <= '0;
            checksum   <= '0;
            oor        <= 1'b0;
        end else begin
            rom_we <= '0;
            if (load_entry) begin
                byte_count <= '0;
                checksum   <= '0;
                oor        <= 1'b0;
            end else if (accept_wr) begin
                if (dec_in_range) begin
                    rom_we   <= dec_sel;
                    rom_addr <= dec_offset;
                    rom_data <= ioctl_dout;
                    checksum <= checksum + ioctl_dout;
                    if (byte_count != BYTE_COUNT_MAX) begin
                        byte_count <= byte_count + 18'd1;
                    end
                end else begin
                    oor <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/rom_load_ctrl.md
ROM_LOAD_CTRL -- requirements
Module: rom_load_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 256: cycles core_reset stays high after a good load.
REQ-002 SHALL have parameter ADDR_W, default 17: width of the ROM-side address.
REQ-003 SHALL have port clk_sys  in  1: the one clock; all logic on its rising edge.
REQ-004 SHALL have port reset_n  in  1: reset, synchronous and active-low.
REQ-005 SHALL have port ioctl_download  in  1: a download session is active.
REQ-006 SHALL have port ioctl_wr  in  1: one-cycle byte strobe.
REQ-007 SHALL have port ioctl_addr  in  25: download byte address.
REQ-008 SHALL have port ioctl_dout  in  8: download byte.
REQ-009 SHALL have port rom_addr  out  ADDR_W: address offset within the selected region.
REQ-010 SHALL have port rom_data  out  8: byte to write.
REQ-011 SHALL have port rom_we  out  4: one-hot write enable, one bit per region (0 CPU, 1 GFX, 2 SND, 3 PROM).
REQ-012 SHALL have port core_reset  out  1: active-high hold for the game core.
REQ-013 SHALL have port load_done  out  1: last load was good and the core is running.
REQ-014 SHALL have port load_error  out  1: last load was short, long or out of range.
REQ-015 SHALL have port byte_count  out  18: bytes accepted in the current or last session.
REQ-016 SHALL have port checksum  out  8: modulo-256 sum of the accepted bytes.

Function
REQ-017 Region map SHALL be: CPU 0x00000-0x07FFF, GFX 0x08000-0x0FFFF, SND 0x10000-0x107FF, PROM 0x10800-0x10FFF; expected total TOTAL_BYTES = 0x11000.
REQ-018 The FSM SHALL have states IDLE, LOAD, CHECK, SETTLE, RUN and ERROR.
REQ-019 IDLE->LOAD SHALL occur on a rising ioctl_download edge; entering LOAD clears byte_count, checksum, load_done, load_error and the out-of-range (oor) flag.
REQ-020 In LOAD, each ioctl_wr with ioctl_addr < TOTAL_BYTES SHALL, exactly one cycle later, assert the region's rom_we bit for one cycle with registered rom_addr (address minus region base) and rom_data; byte_count increments and checksum adds the byte.
REQ-021 An ioctl_wr with ioctl_addr >= TOTAL_BYTES SHALL produce no rom_we, SHALL not be counted, and SHALL set oor.
REQ-022 An ioctl_wr outside LOAD SHALL be ignored entirely.
REQ-023 LOAD->CHECK SHALL occur on a falling ioctl_download edge; an ioctl_wr in that same cycle is still accepted.
REQ-024 CHECK (one cycle) SHALL go to SETTLE if byte_count == TOTAL_BYTES and oor == 0, else to ERROR.
REQ-025 SETTLE SHALL count SETTLE_CYC cycles, then go to RUN.
REQ-026 core_reset SHALL be 1 in every state except RUN.
REQ-027 load_done SHALL be 1 only in RUN.
REQ-028 load_error SHALL be 1 in ERROR and SHALL persist until the next LOAD entry.
REQ-029 A rising ioctl_download edge in RUN, ERROR or SETTLE SHALL go to LOAD immediately (re-download); a SETTLE in progress is aborted.
REQ-030 byte_count SHALL saturate at 0x3FFFF.
REQ-031 rom_we SHALL never have more than one bit set.

Reset
REQ-032 With reset_n low at a clock edge, the block SHALL take: state IDLE, rom_we 0, rom_addr 0, rom_data 0, core_reset 1, load_done 0, load_error 0, byte_count 0, checksum 0, oor 0, settle counter 0, edge-detect register 0.
REQ-033 Reset asserted mid-LOAD SHALL abort the session; a session still in progress when reset releases is not entered until ioctl_download next rises.

Structure
REQ-034 A shared package SHALL hold the state enum, the region base/size constants, TOTAL_BYTES and the region index constants.
REQ-035 The region decode (address -> one-hot select plus offset) SHALL be one sub-module, rom_region_dec, purely combinational.

Verification
REQ-036 Full load: bytes 0x00000-0x10FFF, each byte = addr[7:0] -> rom_we per map, PROM offset 0x000 at addr 0x10800, checksum 0x00, core_reset falls exactly SETTLE_CYC+1 cycles after the download falls, load_done=1.
REQ-037 Short load: 0x10FFF bytes -> ERROR, load_error=1, core_reset=1.
REQ-038 Out-of-range: full load plus a write at 0x11000 -> that write gives no rom_we, byte_count 0x11000, ERROR.
REQ-039 Re-download: new ioctl_download rise at RUN -> core_reset=1 the next cycle, counters cleared.
REQ-040 Abort: reset_n low mid-LOAD at byte 0x5000 -> all outputs at reset values, then a clean full load passes.
REQ-041 Boundary: ioctl_wr at 0x07FFF then 0x08000 back-to-back -> rom_we 0001 then 0010 on consecutive cycles, rom_addr 0x7FFF then 0x0000; ioctl_wr coincident with the download falling edge is counted.
